// File: rtl/mfm_seq_pkg.sv
// mfm_seq_pkg: shared states, status codes, address-mark bytes and CRC polynomial for the MFM sector sequencer
package mfm_seq_pkg;
   typedef enum logic [3:0] {
      S_IDLE, S_HUNT_ID, S_ID_MARK, S_ID_FIELD, S_COMPARE,
      S_HUNT_DATA, S_DATA_MARK, S_DATA, S_DATA_CRC, S_FINISH
   } state_e;
   localparam logic [2:0] ST_OK        = 3'd0;
   localparam logic [2:0] ST_NOT_FOUND = 3'd1;
   localparam logic [2:0] ST_ID_CRC    = 3'd2;
   localparam logic [2:0] ST_NO_DAM    = 3'd3;
   localparam logic [2:0] ST_DATA_CRC  = 3'd4;
   localparam logic [7:0] IDAM = 8'hFE;
   localparam logic [7:0] DAM  = 8'hFB;
   localparam logic [7:0] DDAM = 8'hF8;
   localparam logic [15:0] CRC_POLY = 16'h1021;
endpackage

// File: rtl/mfm_crc16.sv
// mfm_crc16: byte-wide CRC-16-CCITT (MSB first) with preset load; crc_o reads zero after a field plus its own good CRC
module mfm_crc16
   import mfm_seq_pkg::*;
#(
   parameter logic [15:0] PRESET = 16'hCDB4
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        load_i,
   input  logic        upd_i,
   input  logic [7:0]  byte_i,
   output logic [15:0] crc_o
);
   logic [15:0] crc_q, crc_d;
   // fold one byte into the running CRC, eight polynomial steps
   always_comb begin
      crc_d = crc_q ^ {byte_i, 8'h00};
      for (int i = 0; i < 8; i++) crc_d = crc_d[15] ? ({crc_d[14:0], 1'b0} ^ CRC_POLY) : {crc_d[14:0], 1'b0};
   end
   // preset on a sync mark, otherwise update on each accepted byte
   always_ff @(posedge clk_i) begin
      if (!reset_ni) crc_q <= 16'h0000;
      else if (load_i) crc_q <= PRESET;
      else if (upd_i) crc_q <= crc_d;
   end
   assign crc_o = crc_q;
endmodule

// File: rtl/mfm_sector_sequencer.sv
// mfm_sector_sequencer: finds a target ID field in the decoded MFM byte stream and streams its sector payload.
// Define MFM_SEQ_CRC_CHECK_EN to build the CRC engine and report ID/data CRC errors; without it the CRC bytes are only consumed.
module mfm_sector_sequencer
   import mfm_seq_pkg::*;
#(
   parameter int          SECTOR_BYTES = 512,
   parameter int          DAM_WINDOW   = 43,
   parameter int          INDEX_LIMIT  = 2,
   parameter logic [15:0] CRC_PRESET   = 16'hCDB4
) (
   input  logic        clk_50,
   input  logic        reset,
   input  logic        cmd_start,
   input  logic [15:0] tgt_cyl,
   input  logic [3:0]  tgt_head,
   input  logic [7:0]  tgt_sector,
   input  logic [7:0]  byte_in,
   input  logic        byte_stb,
   input  logic        mark_det,
   input  logic        index_pulse,
   output logic [7:0]  data_out,
   output logic        data_out_vld,
   output logic        busy,
   output logic        done,
   output logic [2:0]  status
);
   state_e      st_q;
   logic [15:0] cyl_q, id_cyl_q;
   logic [3:0]  head_q, id_head_q;
   logic [7:0]  sec_q, id_sec_q, data_out_q;
   logic [10:0] cnt_q;
   logic [2:0]  idx_q, idx_d, status_q;
   logic        busy_q, done_q, data_out_vld_q;
   logic [15:0] residue;
   logic        hunt, idx_hit, id_match, crc_bad, id_last;

   assign hunt     = st_q inside {S_HUNT_ID, S_ID_MARK, S_ID_FIELD, S_COMPARE};
   assign idx_d    = (hunt && index_pulse && idx_q != 3'd7) ? idx_q + 3'd1 : idx_q;
   assign idx_hit  = hunt && idx_d >= 3'(INDEX_LIMIT);
   assign id_match = {id_cyl_q, id_head_q, id_sec_q} == {cyl_q, head_q, sec_q};
   assign crc_bad  = residue != 16'h0000;
   assign id_last  = st_q == S_ID_FIELD && byte_stb && cnt_q == 11'd5;

`ifdef MFM_SEQ_CRC_CHECK_EN
   logic crc_load, crc_upd;
   assign crc_load = mark_det && (st_q == S_HUNT_ID || st_q == S_HUNT_DATA);
   assign crc_upd  = byte_stb && (st_q inside {S_ID_MARK, S_ID_FIELD, S_DATA_MARK, S_DATA} ||
                                  (st_q == S_DATA_CRC && cnt_q < 11'd2));
   mfm_crc16 #(.PRESET(CRC_PRESET)) u_crc (
      .clk_i   (clk_50),
      .reset_ni(reset),
      .load_i  (crc_load),
      .upd_i   (crc_upd),
      .byte_i  (byte_in),
      .crc_o   (residue)
   );
`else
   assign residue = CRC_PRESET & 16'h0000;
`endif

   // sector read sequencer; the trailing index check lets an ID completing this cycle beat a timeout
   always_ff @(posedge clk_50) begin
      if (!reset) begin
         st_q           <= S_IDLE;
         cyl_q          <= '0;
         head_q         <= '0;
         sec_q          <= '0;
         id_cyl_q       <= '0;
         id_head_q      <= '0;
         id_sec_q       <= '0;
         cnt_q          <= '0;
         idx_q          <= '0;
         status_q       <= ST_OK;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         data_out_q     <= '0;
         data_out_vld_q <= 1'b0;
      end else begin
         done_q         <= 1'b0;
         data_out_vld_q <= 1'b0;
         idx_q          <= idx_d;
         case (st_q)
            S_IDLE: if (cmd_start) begin
               cyl_q    <= tgt_cyl;
               head_q   <= tgt_head;
               sec_q    <= tgt_sector;
               idx_q    <= '0;
               busy_q   <= 1'b1;
               status_q <= ST_OK;
               st_q     <= S_HUNT_ID;
            end
            S_HUNT_ID: if (mark_det) st_q <= S_ID_MARK;
            S_ID_MARK: if (byte_stb) begin
               cnt_q <= '0;
               st_q  <= byte_in == IDAM ? S_ID_FIELD : S_HUNT_ID;
            end
            S_ID_FIELD: if (byte_stb) begin
               case (cnt_q[2:0])
                  3'd0:    id_cyl_q[15:8] <= byte_in;
                  3'd1:    id_cyl_q[7:0]  <= byte_in;
                  3'd2:    id_head_q      <= byte_in[3:0];
                  3'd3:    id_sec_q       <= byte_in;
                  default: ;
               endcase
               cnt_q <= cnt_q + 11'd1;
               if (id_last) st_q <= S_COMPARE;
            end
            S_COMPARE: begin
               cnt_q <= '0;
               st_q  <= crc_bad ? S_FINISH : id_match ? S_HUNT_DATA : S_HUNT_ID;
               if (crc_bad) status_q <= ST_ID_CRC;
            end
            S_HUNT_DATA: if (mark_det) st_q <= S_DATA_MARK;
            else if (byte_stb) begin
               cnt_q <= cnt_q + 11'd1;
               if (cnt_q == 11'(DAM_WINDOW - 1)) begin
                  status_q <= ST_NO_DAM;
                  st_q     <= S_FINISH;
               end
            end
            S_DATA_MARK: if (byte_stb) begin
               cnt_q <= '0;
               if (byte_in == DAM || byte_in == DDAM) st_q <= S_DATA;
               else begin
                  status_q <= ST_NO_DAM;
                  st_q     <= S_FINISH;
               end
            end
            S_DATA: if (byte_stb) begin
               data_out_q     <= byte_in;
               data_out_vld_q <= 1'b1;
               cnt_q          <= cnt_q == 11'(SECTOR_BYTES - 1) ? 11'd0 : cnt_q + 11'd1;
               if (cnt_q == 11'(SECTOR_BYTES - 1)) st_q <= S_DATA_CRC;
            end
            S_DATA_CRC: if (cnt_q == 11'd2) begin
               status_q <= crc_bad ? ST_DATA_CRC : ST_OK;
               st_q     <= S_FINISH;
            end else if (byte_stb) cnt_q <= cnt_q + 11'd1;
            S_FINISH: begin
               done_q <= 1'b1;
               busy_q <= 1'b0;
               st_q   <= S_IDLE;
            end
            default: st_q <= S_IDLE;
         endcase
         if (idx_hit && !id_last && !(st_q == S_COMPARE && (crc_bad || id_match))) begin
            status_q <= ST_NOT_FOUND;
            st_q     <= S_FINISH;
         end
      end
   end

   assign data_out     = data_out_q;
   assign data_out_vld = data_out_vld_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign status       = status_q;
endmodule

// File: tb/tb_mfm_sector_sequencer.sv
// tb_mfm_sector_sequencer: directed sector-read scenarios with hand-derived expectations
module tb_mfm_sector_sequencer;
   logic        clk_50 = 1'b0, reset = 1'b0, cmd_start = 1'b0;
   logic        byte_stb = 1'b0, mark_det = 1'b0, index_pulse = 1'b0;
   logic [15:0] tgt_cyl = '0;
   logic [3:0]  tgt_head = '0;
   logic [7:0]  tgt_sector = '0, byte_in = '0;
   logic [7:0]  data_out;
   logic        data_out_vld, busy, done;
   logic [2:0]  status;
   logic [15:0] crc = 16'hCDB4;
   int errors = 0, checks = 0;
   int vld_cnt = 0, bad_cnt = 0, done_cnt = 0, pos = 0;
   int v0, b0, d0;

   always #10 clk_50 = ~clk_50;

   mfm_sector_sequencer dut (
      .clk_50      (clk_50),
      .reset       (reset),
      .cmd_start   (cmd_start),
      .tgt_cyl     (tgt_cyl),
      .tgt_head    (tgt_head),
      .tgt_sector  (tgt_sector),
      .byte_in     (byte_in),
      .byte_stb    (byte_stb),
      .mark_det    (mark_det),
      .index_pulse (index_pulse),
      .data_out    (data_out),
      .data_out_vld(data_out_vld),
      .busy        (busy),
      .done        (done),
      .status      (status)
   );

   // payload monitor: every emitted byte must follow 0x00,0x01,... from the start of the operation
   always @(negedge clk_50) begin
      if (done === 1'b1) done_cnt++;
      if (data_out_vld === 1'b1) begin
         if (data_out !== pos[7:0]) bad_cnt++;
         vld_cnt++;
         pos++;
      end else if (busy !== 1'b1) pos = 0;
   end

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
      for (int i = 7; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ b[i]) ? 16'h1021 : 16'h0000);
      return c;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk_50);
      byte_in  = b;
      byte_stb = 1'b1;
      crc      = crc_step(crc, b);
      @(negedge clk_50);
      byte_stb = 1'b0;
   endtask

   task automatic mark();
      @(negedge clk_50);
      mark_det = 1'b1;
      crc      = 16'hCDB4;
      @(negedge clk_50);
      mark_det = 1'b0;
   endtask

   task automatic pulse_index();
      @(negedge clk_50);
      index_pulse = 1'b1;
      @(negedge clk_50);
      index_pulse = 1'b0;
   endtask

   task automatic send_crc(input logic flip);
      logic [15:0] c;
      c = crc;
      send(c[15:8]);
      send(c[7:0] ^ {7'b0, flip});
   endtask

   task automatic send_id(input logic [15:0] cy, input logic [3:0] h, input logic [7:0] s, input logic flip);
      mark();
      send(8'hFE);
      send(cy[15:8]);
      send(cy[7:0]);
      send({4'h0, h});
      send(s);
      send_crc(flip);
   endtask

   task automatic gap(input int n);
      repeat (n) send(8'h4E);
   endtask

   task automatic send_data(input logic pat);
      mark();
      send(8'hFB);
      for (int i = 0; i < 512; i++) send(pat ? 8'(i) : 8'hAA);
      send_crc(1'b0);
   endtask

   task automatic start(input logic [15:0] cy, input logic [3:0] h, input logic [7:0] s);
      @(negedge clk_50);
      tgt_cyl    = cy;
      tgt_head   = h;
      tgt_sector = s;
      cmd_start  = 1'b1;
      @(negedge clk_50);
      cmd_start  = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy === 1'b1 && n < 2000) begin
         @(negedge clk_50);
         n++;
      end
      chk(tag, 32'(busy), 32'd0);
      @(negedge clk_50);
   endtask

   task automatic snap();
      v0 = vld_cnt;
      b0 = bad_cnt;
      d0 = done_cnt;
   endtask

   initial begin
      repeat (3) @(negedge clk_50);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_vld", 32'(data_out_vld), 32'd0);
      chk("rst_data", 32'(data_out), 32'd0);
      chk("rst_status", 32'(status), 32'd0);
      reset = 1'b1;
      @(negedge clk_50);

      snap();
      start(16'h0012, 4'd3, 8'd7);
      chk("clean_busy_on_cmd", 32'(busy), 32'd1);
      send_id(16'h0012, 4'd3, 8'd7, 1'b0);
      gap(20);
      send_data(1'b1);
      wait_idle("clean_idle");
      chk("clean_done_pulse_width", 32'(done), 32'd0);
      chk("clean_status", 32'(status), 32'd0);
      chk("clean_vld_count", 32'(vld_cnt - v0), 32'd512);
      chk("clean_bad_bytes", 32'(bad_cnt - b0), 32'd0);
      chk("clean_done_count", 32'(done_cnt - d0), 32'd1);

      snap();
      start(16'h0012, 4'd3, 8'd7);
      start(16'h0012, 4'd3, 8'd6);
      send_id(16'h0012, 4'd3, 8'd6, 1'b0);
      gap(10);
      send_data(1'b0);
      gap(10);
      send_id(16'h0012, 4'd3, 8'd7, 1'b0);
      gap(20);
      send_data(1'b1);
      wait_idle("skip_idle");
      chk("skip_status", 32'(status), 32'd0);
      chk("skip_vld_count", 32'(vld_cnt - v0), 32'd512);
      chk("skip_bad_bytes", 32'(bad_cnt - b0), 32'd0);
      chk("skip_done_count", 32'(done_cnt - d0), 32'd1);

      snap();
      start(16'h0012, 4'd3, 8'd9);
      send_id(16'h0012, 4'd3, 8'd7, 1'b0);
      pulse_index();
      gap(5);
      chk("nf_busy_after_1st_index", 32'(busy), 32'd1);
      pulse_index();
      wait_idle("nf_idle");
      chk("nf_status", 32'(status), 32'd1);
      chk("nf_done_count", 32'(done_cnt - d0), 32'd1);
      pulse_index();
      repeat (3) @(negedge clk_50);
      chk("nf_status_held", 32'(status), 32'd1);
      chk("nf_no_second_done", 32'(done_cnt - d0), 32'd1);
      chk("nf_vld_count", 32'(vld_cnt - v0), 32'd0);

      snap();
      start(16'h0012, 4'd3, 8'd7);
      chk("status_cleared_on_cmd", 32'(status), 32'd0);
      send_id(16'h0012, 4'd3, 8'd7, 1'b1);
      gap(20);
      send_data(1'b1);
      wait_idle("idcrc_idle");
`ifdef MFM_SEQ_CRC_CHECK_EN
      chk("idcrc_status", 32'(status), 32'd2);
      chk("idcrc_vld_count", 32'(vld_cnt - v0), 32'd0);
`else
      chk("idcrc_status", 32'(status), 32'd0);
      chk("idcrc_vld_count", 32'(vld_cnt - v0), 32'd512);
`endif
      chk("idcrc_done_count", 32'(done_cnt - d0), 32'd1);

      snap();
      start(16'h0012, 4'd3, 8'd7);
      send_id(16'h0012, 4'd3, 8'd7, 1'b0);
      gap(42);
      chk("nodam_busy_at_42", 32'(busy), 32'd1);
      send(8'h4E);
      wait_idle("nodam_idle");
      chk("nodam_status", 32'(status), 32'd3);
      chk("nodam_vld_count", 32'(vld_cnt - v0), 32'd0);

      snap();
      start(16'h0012, 4'd3, 8'd7);
      send_id(16'h0012, 4'd3, 8'd7, 1'b0);
      gap(20);
      mark();
      send(8'hFB);
      for (int i = 0; i < 100; i++) send(8'(i));
      @(negedge clk_50);
      reset = 1'b0;
      @(negedge clk_50);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_vld_count", 32'(vld_cnt - v0), 32'd100);
      reset = 1'b1;
      repeat (2) @(negedge clk_50);
      chk("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
      snap();
      start(16'h0012, 4'd3, 8'd7);
      send_id(16'h0012, 4'd3, 8'd7, 1'b0);
      gap(20);
      send_data(1'b1);
      wait_idle("rerun_idle");
      chk("rerun_status", 32'(status), 32'd0);
      chk("rerun_vld_count", 32'(vld_cnt - v0), 32'd512);
      chk("rerun_bad_bytes", 32'(bad_cnt - b0), 32'd0);
      chk("rerun_done_count", 32'(done_cnt - d0), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
